mem_uart_bridge: RTL and testbench
==================================

MEM_UART_BRIDGE -- requirements
Module: mem_uart_bridge

Interface
REQ-001: Parameter BaseAddr, default 32'h1000_0000, byte address of the 16-byte register window (aligned to 16).
REQ-002: Parameter FifoDepth, default 4, entries per TX and RX FIFO (power of two, 2..16).
REQ-003: clk_i  input  1  single clock; all logic rises on posedge clk_i.
REQ-004: reset_ni  input  1  asynchronous, active-low reset.
REQ-005: mem_valid_i  input  1  picorv32 native bus request valid.
REQ-006: mem_addr_i  input  32  byte address of the request.
REQ-007: mem_wdata_i  input  32  write data.
REQ-008: mem_wstrb_i  input  4  byte write strobes; all-zero means read.
REQ-009: mem_ready_o  output  1  one-cycle completion pulse for a request inside the window.
REQ-010: mem_rdata_o  output  32  read data, valid while mem_ready_o=1, zero otherwise.
REQ-011: sel_o  output  1  combinational; 1 when mem_valid_i=1 and mem_addr_i[31:4]==BaseAddr[31:4].
REQ-012: tx_data_o  output  8  byte to the UART transmitter (TX FIFO head).
REQ-013: tx_valid_o  output  1  TX FIFO not empty.
REQ-014: tx_ready_i  input  1  transmitter accepts tx_data_o when tx_valid_o=1 and tx_ready_i=1.
REQ-015: rx_data_i  input  8  byte from the UART receiver.
REQ-016: rx_valid_i  input  1  rx_data_i valid for one handshake.
REQ-017: rx_ready_o  output  1  constant 1; the bridge always accepts, and drops the byte on overflow.

Function
REQ-018: Register map (offset = mem_addr_i[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 reserved (reads 0, writes ignored).
REQ-019: TXDATA write (mem_wstrb_i[0]=1) pushes mem_wdata_i[7:0]; a write with mem_wstrb_i[0]=0 completes and pushes nothing; reads return 0.
REQ-020: RXDATA read, FIFO non-empty: returns {24'h0, head byte} and pops exactly once in the ready cycle. Empty: returns 32'hFFFF_FFFF and pops nothing. Writes are ignored.
REQ-021: STATUS read: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 rx_overrun (sticky), bits[11:8] rx_count (saturated at 15), all other bits 0.
REQ-022: A STATUS read clears rx_overrun in the ready cycle; an overrun in that same cycle leaves it set.
REQ-023: Bus FSM states IDLE, RESP.
REQ-024: IDLE->RESP when sel_o=1 and the access is not a TXDATA byte-0 write to a full TX FIFO; such writes stall in IDLE until a slot frees.
REQ-025: RESP asserts mem_ready_o for exactly one cycle, performs the push/pop, then returns to IDLE; mem_valid_i is ignored in RESP.
REQ-026: Latency: mem_ready_o rises on the second clock edge after mem_valid_i rises, unless stalled.
REQ-027: Requests outside the window: mem_ready_o and mem_rdata_o stay 0, no state change.
REQ-028: TX pop on tx_valid_o & tx_ready_i; tx_data_o is registered FIFO head, stable until popped.
REQ-029: RX push on rx_valid_i when not full; if full, byte discarded and rx_overrun set.
REQ-030: Simultaneous push and pop on one FIFO in one cycle: both occur, count unchanged; a push to a full FIFO with a simultaneous pop succeeds.
REQ-031: Pointers wrap modulo FifoDepth; counts are clog2(FifoDepth)+1 bits and never exceed FifoDepth.

Reset
REQ-032: reset_ni=0 asynchronously forces FSM to IDLE, both FIFOs empty, rx_overrun=0, mem_ready_o=0, mem_rdata_o=0, tx_valid_o=0, tx_data_o=0.
REQ-033: Reset mid-transaction abandons the request with no pending ready pulse; rx_ready_o stays 1 throughout reset.

Verification
REQ-034: After reset, read STATUS at BaseAddr+8 -> mem_rdata_o=32'h0000_0006, one ready pulse two edges after valid.
REQ-035: Write 0x41,0x42 to TXDATA, tx_ready_i=1 -> tx_data_o emits 0x41 then 0x42, then tx_valid_o=0.
REQ-036: With tx_ready_i=0, write 5 bytes -> the fifth write stalls; a one-cycle tx_ready_i pulse lets it complete with mem_ready_o=1.
REQ-037: Push 5 RX bytes 0x10..0x14 -> STATUS=32'h0000_0418 (rx_count 4, rx_full, overrun); RXDATA reads 0x10..0x13 then 32'hFFFF_FFFF; next STATUS bit4=0.
REQ-038: Access at BaseAddr+0x10 -> mem_ready_o stays 0, sel_o=0, FIFOs unchanged.
REQ-039: Deassert reset_ni in RESP with two TX bytes queued -> no ready pulse, tx_valid_o=0 immediately, STATUS reads 32'h0000_0006 after release.

Source files
------------

// File: rtl/mem_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_uart_bridge
// Description : picorv32 native-bus register window bridging to byte-wide
//               UART TX/RX streams through two small FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================

module mem_uart_bridge_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cw'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module mem_uart_bridge #(
    parameter logic [31:0] BaseAddr  = 32'h1000_0000,
    parameter int          FifoDepth = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        sel_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o
);
    localparam int          c_cw         = $clog2(FifoDepth) + 1;
    localparam logic [0:0]  c_st_idle    = 1'b0;
    localparam logic [0:0]  c_st_resp    = 1'b1;
    localparam logic [1:0]  c_reg_txdata = 2'd0;
    localparam logic [1:0]  c_reg_rxdata = 2'd1;
    localparam logic [1:0]  c_reg_status = 2'd2;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [1:0]      r_req_off;
    logic            r_req_wr;
    logic            r_req_wb0;
    logic [7:0]      r_req_byte;
    logic            r_ready;
    logic [31:0]     r_rdata;
    logic            r_rx_ovr;

    logic            w_start;
    logic            w_tx_stall;
    logic            w_tx_push;
    logic            w_tx_pop;
    logic            w_rx_pop;
    logic            w_rx_ovr_set;
    logic            w_status_rd;
    logic [31:0]     w_rdata_next;
    logic [31:0]     w_status;
    logic            w_tx_full;
    logic            w_tx_empty;
    logic            w_rx_full;
    logic            w_rx_empty;
    logic [7:0]      w_rx_head;
    logic [c_cw-1:0] w_tx_count;
    logic [c_cw-1:0] w_rx_count;
    logic [4:0]      w_rx_count_ext;
    logic [3:0]      w_rx_count_sat;
    logic            w_unused;

    assign sel_o       = mem_valid_i && (mem_addr_i[31:4] == BaseAddr[31:4]);
    assign rx_ready_o  = 1'b1;
    assign tx_valid_o  = !w_tx_empty;
    assign w_tx_pop    = tx_valid_o && tx_ready_i;
    assign mem_ready_o = r_ready;
    assign mem_rdata_o = r_rdata;
    assign w_unused    = ^{mem_wdata_i[31:8], mem_addr_i[1:0], w_tx_count};

    // Byte-0 TXDATA writes wait in IDLE until the transmitter frees a slot.
    assign w_tx_stall = (mem_addr_i[3:2] == c_reg_txdata) && mem_wstrb_i[0] && w_tx_full;
    // r_ready blocks re-acceptance while the master still holds valid in the
    // cycle it samples the ready pulse.
    assign w_start    = (r_state == c_st_idle) && sel_o && !w_tx_stall && !r_ready;

    assign w_rx_count_ext = 5'(w_rx_count);
    assign w_rx_count_sat = (w_rx_count_ext > 5'd15) ? 4'hF : w_rx_count_ext[3:0];
    assign w_status = {20'h0, w_rx_count_sat, 3'b000, r_rx_ovr,
                       w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

    // A discarded byte that coincides with a STATUS read must not be lost.
    assign w_rx_ovr_set = rx_valid_i && w_rx_full && !w_rx_pop;

    mem_uart_bridge_fifo #(.DEPTH(FifoDepth), .WIDTH(8)) u_tx_fifo (
        .clk     (clk_i),
        .rst_n   (reset_ni),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_wdata (r_req_byte),
        .o_rdata (tx_data_o),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    mem_uart_bridge_fifo #(.DEPTH(FifoDepth), .WIDTH(8)) u_rx_fifo (
        .clk     (clk_i),
        .rst_n   (reset_ni),
        .i_push  (rx_valid_i),
        .i_pop   (w_rx_pop),
        .i_wdata (rx_data_i),
        .o_rdata (w_rx_head),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_start) w_state_next = c_st_resp;
            c_st_resp: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_tx_push    = 1'b0;
        w_rx_pop     = 1'b0;
        w_status_rd  = 1'b0;
        w_rdata_next = '0;
        if (r_state == c_st_resp) begin
            case (r_req_off)
                c_reg_txdata: w_tx_push = r_req_wb0;
                c_reg_rxdata: begin
                    if (!r_req_wr) begin
                        if (w_rx_empty) begin
                            w_rdata_next = 32'hFFFF_FFFF;
                        end else begin
                            w_rdata_next = {24'h0, w_rx_head};
                            w_rx_pop     = 1'b1;
                        end
                    end
                end
                c_reg_status: begin
                    if (!r_req_wr) begin
                        w_status_rd  = 1'b1;
                        w_rdata_next = w_status;
                    end
                end
                default: w_rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_req_off  <= '0;
            r_req_wr   <= 1'b0;
            r_req_wb0  <= 1'b0;
            r_req_byte <= '0;
        end else if (w_start) begin
            r_req_off  <= mem_addr_i[3:2];
            r_req_wr   <= |mem_wstrb_i;
            r_req_wb0  <= mem_wstrb_i[0];
            r_req_byte <= mem_wdata_i[7:0];
        end
    end

    // The pulse and the FIFO side effects share the clock edge leaving RESP.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_rx_ovr <= 1'b0;
        end else begin
            r_ready <= (r_state == c_st_resp);
            r_rdata <= w_rdata_next;
            if (w_rx_ovr_set) begin
                r_rx_ovr <= 1'b1;
            end else if (w_status_rd) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_uart_bridge
// Description : Self-checking bench for mem_uart_bridge against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_uart_bridge;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        mem_valid_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic        sel_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic [7:0] tx_seen[$];
    int         m_tx_occ = 0;
    bit         m_ovr = 1'b0;

    always #5 clk = ~clk;

    mem_uart_bridge #(.BaseAddr(BASE), .FifoDepth(DEPTH)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .mem_valid_i (mem_valid_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .sel_o       (sel_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o)
    );

    // Transmitter-side monitor: records each byte accepted by the handshake.
    always @(posedge clk) begin
        if (tx_valid_o && tx_ready_i) tx_seen.push_back(tx_data_o);
    end

    function automatic logic [31:0] exp_status();
        int c;
        logic [3:0] sat;
        c   = m_rx.size();
        sat = (c > 15) ? 4'd15 : 4'(c);
        return {20'h0, sat, 3'b000, m_ovr, (c == DEPTH), (c == 0),
                (m_tx_occ == 0), (m_tx_occ == DEPTH)};
    endfunction

    // One bus access; optionally presents an RX byte during the RESP cycle.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit inject, input logic [7:0] ib,
                       output logic [31:0] rdata, output int lat);
        @(negedge clk);
        mem_valid_i = 1'b1; mem_addr_i = addr; mem_wdata_i = wdata; mem_wstrb_i = wstrb;
        lat = -1; rdata = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (inject && i == 1) begin rx_valid_i = 1'b1; rx_data_i = ib; end
            else rx_valid_i = 1'b0;
            if (mem_ready_o) begin lat = i; rdata = mem_rdata_o; break; end
        end
        mem_valid_i = 1'b0; mem_wstrb_i = 4'h0; rx_valid_i = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk);
        rx_valid_i = 1'b1; rx_data_i = b;
        @(negedge clk);
        rx_valid_i = 1'b0;
        if (m_rx.size() < DEPTH) m_rx.push_back(b); else m_ovr = 1'b1;
    endtask

    task automatic drain_tx();
        @(negedge clk);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tx_valid_o) break;
        end
        tx_ready_i = 1'b0;
        m_tx_occ = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat;
        reset_ni = 1'b0; mem_valid_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
        mem_wstrb_i = '0; tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_ready_o !== 1'b1) begin bad++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready_o); end
        reset_ni = 1'b1;
        @(negedge clk);
        total++; if ({mem_ready_o, mem_rdata_o} !== 33'h0) begin bad++; $display("FAIL rst_bus got=%b/%h exp=0/0", mem_ready_o, mem_rdata_o); end
        total++; if ({tx_valid_o, tx_data_o} !== 9'h0) begin bad++; $display("FAIL rst_tx got=%b/%h exp=0/00", tx_valid_o, tx_data_o); end
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== 32'h0000_0006) begin bad++; $display("FAIL rst_status got=%h exp=00000006", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL rst_latency got=%0d exp=2", lat); end
        @(negedge clk);
        total++; if ({mem_ready_o, mem_rdata_o} !== 33'h0) begin bad++; $display("FAIL ready_one_cycle got=%b/%h exp=0/0", mem_ready_o, mem_rdata_o); end
    endtask

    task automatic test_tx_basic();
        logic [31:0] rd; int lat;
        @(negedge clk); tx_ready_i = 1'b1;
        bus(BASE, 32'hDEAD_BE41, 4'hF, 1'b0, 8'h0, rd, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL tx41_latency got=%0d exp=2", lat); end
        bus(BASE, 32'h0000_0042, 4'h1, 1'b0, 8'h0, rd, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL tx42_latency got=%0d exp=2", lat); end
        repeat (4) @(negedge clk);
        total++; if (tx_seen.size() !== 2 || tx_seen[0] !== 8'h41 || tx_seen[1] !== 8'h42)
            begin bad++; $display("FAIL tx_order got_n=%0d exp=41,42", tx_seen.size()); end
        total++; if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL tx_valid_after got=%b exp=0", tx_valid_o); end
        tx_ready_i = 1'b0; tx_seen.delete();
    endtask

    task automatic test_regs();
        logic [31:0] rd; int lat;
        bus(BASE, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h exp=0", rd); end
        bus(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 1'b0, 8'h0, rd, lat);
        bus(BASE + 32'hC, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== 32'h0 || lat !== 2) begin bad++; $display("FAIL reserved got=%h lat=%0d exp=0 lat=2", rd, lat); end
        bus(BASE, 32'h0000_0099, 4'h2, 1'b0, 8'h0, rd, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL txdata_nob0 got=%0d exp=2", lat); end
        bus(BASE + 32'h4, 32'h0000_0011, 4'hF, 1'b0, 8'h0, rd, lat);
        bus(BASE + 32'h4, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rx_empty_read got=%h exp=ffffffff", rd); end
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== exp_status()) begin bad++; $display("FAIL regs_status got=%h exp=%h", rd, exp_status()); end
        @(negedge clk); mem_valid_i = 1'b1; mem_addr_i = BASE + 32'h8; #1;
        total++; if (sel_o !== 1'b1) begin bad++; $display("FAIL sel_in_window got=%b exp=1", sel_o); end
        mem_valid_i = 1'b0; #1;
        total++; if (sel_o !== 1'b0) begin bad++; $display("FAIL sel_no_valid got=%b exp=0", sel_o); end
    endtask

    task automatic test_stall();
        logic [31:0] rd; int lat; logic [7:0] b; bit got;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            bus(BASE, {24'h0, b}, 4'h1, 1'b0, 8'h0, rd, lat);
            m_tx.push_back(b); m_tx_occ++;
        end
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== exp_status()) begin bad++; $display("FAIL tx_full_status got=%h exp=%h", rd, exp_status()); end
        b = 8'($urandom);
        @(negedge clk);
        mem_valid_i = 1'b1; mem_addr_i = BASE; mem_wdata_i = {24'h0, b}; mem_wstrb_i = 4'h1;
        got = 1'b0;
        repeat (5) begin @(negedge clk); if (mem_ready_o) got = 1'b1; end
        total++; if (got !== 1'b0) begin bad++; $display("FAIL stall_no_ready got=%b exp=0", got); end
        tx_ready_i = 1'b1;
        @(negedge clk);
        tx_ready_i = 1'b0;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (mem_ready_o) begin lat = i; break; end
        end
        mem_valid_i = 1'b0; mem_wstrb_i = 4'h0;
        total++; if (lat < 1) begin bad++; $display("FAIL stall_release got=none exp=ready"); end
        m_tx.push_back(b);
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== exp_status()) begin bad++; $display("FAIL stall_status got=%h exp=%h", rd, exp_status()); end
        drain_tx();
        total++; if (tx_seen.size() != m_tx.size()) begin bad++; $display("FAIL stall_tx_count got=%0d exp=%0d", tx_seen.size(), m_tx.size()); end
        else foreach (m_tx[i]) if (tx_seen[i] !== m_tx[i]) begin bad++; $display("FAIL stall_tx_byte%0d got=%h exp=%h", i, tx_seen[i], m_tx[i]); break; end
        tx_seen.delete(); m_tx.delete();
    endtask

    task automatic test_rx_overrun();
        logic [31:0] rd; int lat;
        bus(BASE, 32'h55, 4'h1, 1'b0, 8'h0, rd, lat);
        m_tx.push_back(8'h55); m_tx_occ = 1;
        for (int i = 0; i < 5; i++) rx_send(8'h10 + 8'(i));
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== 32'h0000_0418 || rd !== exp_status()) begin bad++; $display("FAIL ovr_status got=%h exp=00000418", rd); end
        m_ovr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus(BASE + 32'h4, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
            total++;
            if (i < 4 && rd !== {24'h0, 8'h10 + 8'(i)}) begin bad++; $display("FAIL rx_read%0d got=%h exp=%h", i, rd, 8'h10 + 8'(i)); end
            else if (i == 4 && rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rx_read_empty got=%h exp=ffffffff", rd); end
        end
        m_rx.delete();
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== exp_status() || rd[4] !== 1'b0) begin bad++; $display("FAIL ovr_cleared got=%h exp=%h", rd, exp_status()); end
        drain_tx();
        total++; if (tx_seen.size() !== 1 || tx_seen[0] !== 8'h55) begin bad++; $display("FAIL ovr_tx got_n=%0d exp=55", tx_seen.size()); end
        tx_seen.delete(); m_tx.delete();
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd; int lat; logic [7:0] b; logic [31:0] exp;
        for (int i = 0; i < DEPTH; i++) rx_send(8'($urandom));
        b = 8'($urandom);
        exp = {24'h0, m_rx[0]};
        bus(BASE + 32'h4, 32'h0, 4'h0, 1'b1, b, rd, lat);
        void'(m_rx.pop_front()); m_rx.push_back(b);
        total++; if (rd !== exp || lat !== 2) begin bad++; $display("FAIL pushpop_read got=%h lat=%0d exp=%h lat=2", rd, lat, exp); end
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== exp_status()) begin bad++; $display("FAIL pushpop_status got=%h exp=%h", rd, exp_status()); end
        exp = exp_status();
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b1, 8'hEE, rd, lat);
        m_ovr = 1'b1;
        total++; if (rd !== exp) begin bad++; $display("FAIL status_ovr_race got=%h exp=%h", rd, exp); end
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== exp_status()) begin bad++; $display("FAIL ovr_kept got=%h exp=%h", rd, exp_status()); end
        m_ovr = 1'b0;
        while (m_rx.size() > 0) begin
            exp = {24'h0, m_rx.pop_front()};
            bus(BASE + 32'h4, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
            total++; if (rd !== exp) begin bad++; $display("FAIL pushpop_drain got=%h exp=%h", rd, exp); end
        end
    endtask

    task automatic test_window();
        logic [31:0] rd; int lat; bit got;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_valid_i = 1'b1; mem_addr_i = (k == 0) ? BASE + 32'h10 : BASE - 32'h4;
            mem_wdata_i = 32'h77; mem_wstrb_i = 4'h1; #1;
            total++; if (sel_o !== 1'b0) begin bad++; $display("FAIL window_sel%0d got=%b exp=0", k, sel_o); end
            got = 1'b0;
            repeat (5) begin @(negedge clk); if (mem_ready_o || mem_rdata_o !== 32'h0) got = 1'b1; end
            total++; if (got !== 1'b0) begin bad++; $display("FAIL window_ready%0d got=1 exp=0", k); end
            mem_valid_i = 1'b0; mem_wstrb_i = 4'h0;
        end
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== exp_status() || tx_valid_o !== 1'b0) begin bad++; $display("FAIL window_state got=%h exp=%h", rd, exp_status()); end
    endtask

    task automatic test_random();
        logic [31:0] rd; int lat; logic [31:0] exp; int op; logic [7:0] b;
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: if (m_tx_occ < DEPTH) begin
                    b = 8'($urandom);
                    bus(BASE, {24'($urandom), b}, 4'h1 | 4'($urandom_range(0, 15)), 1'b0, 8'h0, rd, lat);
                    m_tx.push_back(b); m_tx_occ++;
                    total++; if (lat !== 2) begin bad++; $display("FAIL rnd_tx_lat n=%0d got=%0d exp=2", n, lat); end
                end
                1: rx_send(8'($urandom));
                2: begin
                    exp = (m_rx.size() == 0) ? 32'hFFFF_FFFF : {24'h0, m_rx.pop_front()};
                    bus(BASE + 32'h4, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
                    total++; if (rd !== exp || lat !== 2) begin bad++; $display("FAIL rnd_rx n=%0d got=%h exp=%h lat=%0d", n, rd, exp, lat); end
                end
                3: begin
                    exp = exp_status();
                    bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
                    m_ovr = 1'b0;
                    total++; if (rd !== exp || lat !== 2) begin bad++; $display("FAIL rnd_status n=%0d got=%h exp=%h lat=%0d", n, rd, exp, lat); end
                end
                default: begin
                    bus(BASE + 32'hC, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
                    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rnd_reserved n=%0d got=%h exp=0", n, rd); end
                end
            endcase
        end
        drain_tx();
        total++; if (tx_seen.size() != m_tx.size()) begin bad++; $display("FAIL rnd_tx_count got=%0d exp=%0d", tx_seen.size(), m_tx.size()); end
        else foreach (m_tx[i]) if (tx_seen[i] !== m_tx[i]) begin bad++; $display("FAIL rnd_tx_byte%0d got=%h exp=%h", i, tx_seen[i], m_tx[i]); break; end
        tx_seen.delete(); m_tx.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; bit got;
        bus(BASE, 32'hA1, 4'h1, 1'b0, 8'h0, rd, lat);
        bus(BASE, 32'hA2, 4'h1, 1'b0, 8'h0, rd, lat);
        @(negedge clk);
        mem_valid_i = 1'b1; mem_addr_i = BASE + 32'h8; mem_wstrb_i = 4'h0;
        @(negedge clk);
        reset_ni = 1'b0; #1;
        total++; if ({tx_valid_o, mem_ready_o, rx_ready_o} !== 3'b001) begin bad++; $display("FAIL midrst_outputs got=%b exp=001", {tx_valid_o, mem_ready_o, rx_ready_o}); end
        mem_valid_i = 1'b0;
        got = 1'b0;
        repeat (2) begin @(negedge clk); if (mem_ready_o) got = 1'b1; end
        reset_ni = 1'b1;
        repeat (4) begin @(negedge clk); if (mem_ready_o) got = 1'b1; end
        total++; if (got !== 1'b0) begin bad++; $display("FAIL midrst_no_ready got=1 exp=0"); end
        m_tx.delete(); m_rx.delete(); m_tx_occ = 0; m_ovr = 1'b0;
        bus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 8'h0, rd, lat);
        total++; if (rd !== 32'h0000_0006) begin bad++; $display("FAIL midrst_status got=%h exp=00000006", rd); end
        total++; if (tx_seen.size() !== 0) begin bad++; $display("FAIL midrst_tx got_n=%0d exp=0", tx_seen.size()); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_regs();
        test_stall();
        test_rx_overrun();
        test_simultaneous();
        test_window();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
